// File: rtl/inv_buf_pipe.sv
// inv_buf_pipe: elastic, back-pressurable data conditioner.
//
// Samples of WIDTH bits enter through a valid/ready handshake. Each accepted
// sample is transformed on entry (pass, invert, masked invert, bit-reverse)
// and carried through DEPTH register stages. Bubbles collapse and order is
// strictly FIFO. The last stage drives the output handshake.
//
// Ports:
//   clock      - single system clock, rising edge
//   reset      - synchronous, active-high reset
//   in_valid   - producer has a sample
//   in_ready   - sample is accepted this cycle (0 while reset is high)
//   in_data    - sample
//   in_mode    - 00 pass, 01 invert, 10 invert where in_mask=1, 11 bit-reverse
//   in_mask    - mask used by mode 10
//   out_valid  - last stage holds an item
//   out_ready  - consumer takes the item this cycle
//   out_data   - item in the last stage
//   occupancy  - number of items in flight
module inv_buf_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    occupancy
);

  // Entry transform applied to each accepted sample.
  function automatic logic [WIDTH-1:0] xform(input logic [WIDTH-1:0] d,
                                             input logic [1:0]       m,
                                             input logic [WIDTH-1:0] mk);
    logic [WIDTH-1:0] r;
    r = d;
    case (m)
      2'b00: r = d;
      2'b01: r = ~d;
      2'b10: r = d ^ mk;
      2'b11: begin
        for (int i = 0; i < WIDTH; i++) begin
          r[i] = d[WIDTH-1-i];
        end
      end
      default: r = d;
    endcase
    return r;
  endfunction

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CW-1:0]    occ_q, occ_d;
  logic [DEPTH-1:0] adv;
  logic             space;
  logic             accept;
  logic             fire;
  logic             in_ready_s;

  // Stage advance: a stage moves when some stage downstream of it is empty
  // or the consumer is taking the last item (the recursive rule unrolled).
  always_comb begin
    space = out_ready;
    adv   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i] = valid_q[i] && space;
      space  = space || !valid_q[i];
    end
  end

  // Handshake decode; in_ready is a combinational path from out_ready.
  always_comb begin
    in_ready_s = !reset && (!valid_q[0] || adv[0]);
    accept     = in_valid && in_ready_s;
    fire       = adv[DEPTH-1];
  end

  // Next-state for stage valid bits, stage data and occupancy.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (accept) begin
      valid_d[0] = 1'b1;
      data_d[0]  = xform(in_data, in_mode, in_mask);
    end else if (adv[0]) begin
      valid_d[0] = 1'b0;
    end else begin
      valid_d[0] = valid_q[0];
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (adv[i-1]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = data_q[i-1];
      end else if (adv[i]) begin
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i] = valid_q[i];
      end
    end
    // Simultaneous accept and fire cancel out.
    occ_d = occ_q + CW'(accept) - CW'(fire);
  end

  // State registers with synchronous reset discarding all in-flight items.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_inv_buf_pipe.sv
// Self-checking bench for inv_buf_pipe (WIDTH=8, DEPTH=4).
// A reference model tracks the items in flight as a queue with the cycle at
// which each may first appear at the output; a monitor compares the DUT.
module tb_inv_buf_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic [WIDTH-1:0] in_mask;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    occupancy;

  inv_buf_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               vis;
  } item_t;

  item_t sbq[$];
  int    cyc    = 0;
  int    total  = 0;
  int    passed = 0;
  bit    mon_en = 1'b0;

  function automatic logic [WIDTH-1:0] ref_xf(input logic [WIDTH-1:0] d,
                                              input logic [1:0] m,
                                              input logic [WIDTH-1:0] mk);
    logic [WIDTH-1:0] r;
    int v;
    case (m)
      2'd0: r = d;
      2'd1: r = 8'd255 - d;
      2'd2: r = d ^ mk;
      default: begin
        v = 0;
        for (int i = 0; i < WIDTH; i++) begin
          if (d[i]) v = v + (1 << (WIDTH - 1 - i));
        end
        r = v[WIDTH-1:0];
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Model update at the clock edge: count edges, record accepted items.
  always @(posedge clock) begin
    item_t it;
    cyc++;
    if (reset) begin
      sbq.delete();
    end else if (in_valid && in_ready) begin
      it.d   = ref_xf(in_data, in_mode, in_mask);
      it.vis = cyc + DEPTH - 1;
      sbq.push_back(it);
    end
  end

  // Monitor: compare outputs mid-cycle and retire items the consumer takes.
  always @(negedge clock) begin
    logic exp_ir, exp_ov;
    if (mon_en) begin
      exp_ir = !reset && (sbq.size() < DEPTH || out_ready);
      exp_ov = (sbq.size() > 0) && (cyc >= sbq[0].vis);
      chk("in_ready", 32'(in_ready), 32'(exp_ir));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("occupancy", 32'(occupancy), 32'(sbq.size()));
      if (exp_ov && out_valid) chk("out_data", 32'(out_data), 32'(sbq[0].d));
      if (exp_ov && out_ready) void'(sbq.pop_front());
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic [1:0] m,
                      input logic [7:0] mk, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    in_mask   = mk;
    out_ready = ordy;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] m,
                      input logic [7:0] mk, input logic ordy);
    logic acc;
    acc = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    in_mode   = m;
    in_mask   = mk;
    out_ready = ordy;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
    end
    if (!acc) begin
      total++;
      $display("FAIL send_timeout: data %0h not accepted, expected acceptance", d);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 2'b00, 8'h00, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_data = 8'h00; in_mode = 2'b00; in_mask = 8'h00; out_ready = 1'b0;
    @(posedge clock); #1;
    mon_en = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;

    // single inverted sample
    send(8'hA5, 2'b01, 8'h00, 1'b1);
    idle(6);

    // back-to-back stream
    for (int i = 0; i < 10; i++) send(8'(i), 2'b00, 8'h00, 1'b1);
    idle(6);

    // fill while stalled, then release with a 5th offered
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), 2'b00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h24, 2'b00, 8'h00, 1'b0);
    send(8'h24, 2'b00, 8'h00, 1'b1);
    idle(6);

    // transforms, with settings changing every cycle
    send(8'h3C, 2'b10, 8'h0F, 1'b1);
    send(8'h01, 2'b11, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++)
      send(8'($urandom), 2'($urandom), 8'($urandom), 1'b1);
    idle(6);

    // full pipeline with one in / one out per cycle
    for (int i = 0; i < 4; i++) send(8'h40 + 8'(i), 2'b00, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) send(8'h50 + 8'(i), 2'b01, 8'h00, 1'b1);
    idle(6);

    // reset with items in flight and a sample offered
    for (int i = 0; i < 3; i++) send(8'h60 + 8'(i), 2'b00, 8'h00, 1'b1);
    reset = 1'b1;
    step(1'b1, 8'h77, 2'b00, 8'h00, 1'b1);
    reset = 1'b0;
    send(8'hA5, 2'b01, 8'h00, 1'b1);
    idle(6);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom), 8'($urandom),
           1'($urandom_range(0, 3) != 0));

    // drain
    for (int i = 0; i < 100 && sbq.size() > 0; i++) step(1'b0, 8'h00, 2'b00, 8'h00, 1'b1);
    total++;
    if (sbq.size() == 0) passed++;
    else $display("FAIL drain: %0d items left, expected 0", sbq.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/inv_buf_pipe.md
Name: inv_buf_pipe

Overview:
- Parametrised, elastic successor to the single-bit buffer/inverter.
- Carries WIDTH-bit samples through DEPTH register stages with valid/ready handshakes on both sides.
- Applies a per-sample transform (pass, invert, masked invert, bit-reverse) at entry.
- Used as a registered, back-pressurable data conditioner between producer and consumer blocks.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of pipeline stages (>=1); also the maximum number of items in flight.
- CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a sample.
- in_ready  output  1  block accepts the sample this cycle.
- in_data  input  WIDTH  sample.
- in_mode  input  2  transform: 00 pass, 01 invert all bits, 10 invert bits where in_mask=1, 11 bit-reverse.
- in_mask  input  WIDTH  mask for mode 10; ignored otherwise.
- out_valid  output  1  stage DEPTH-1 holds an item.
- out_ready  input  1  consumer takes the item this cycle.
- out_data  output  WIDTH  item from stage DEPTH-1.
- occupancy  output  CW  number of valid stages.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clock and reset.
- Reset values: all stage valid bits 0, all stage data 0, out_valid 0, out_data 0, occupancy 0.
- in_ready is forced 0 in any cycle where reset is 1.
- Reset mid-operation: all in-flight items are discarded and never emitted. An in_valid sample presented during reset is not accepted.
- Accept: the transfer happens when in_valid && in_ready at the rising edge.
- Stage 0 captures the transformed data: f(in_data, in_mode, in_mask), sampled at that edge. Mode and mask are fixed per item, so later changes do not affect items already in flight.
- Transform definitions:
  - 01 = ~d.
  - 10 = d ^ in_mask.
  - 11 = d[WIDTH-1-i] mapped to bit i.
- Stage advance rule: stage i (i < DEPTH-1) moves to stage i+1 when stage i+1 is empty or stage i+1 is itself advancing.
- The last stage advances (empties) when out_valid && out_ready.
- Bubbles collapse; order is strictly FIFO.
- in_ready = !valid[0] || stage 0 advancing. This is a combinational path from out_ready through the chain and is accepted by design.
- Latency: an item accepted at edge k shows out_valid=1 in the cycle after edge k+DEPTH-1 (DEPTH cycles from the accept cycle) when unstalled.
- Throughput: 1 item/cycle with out_ready held 1.
- out_data is held stable while out_valid && !out_ready.
- Occupancy: +1 on accept only, -1 on output fire only, unchanged when both or neither occur. It never exceeds DEPTH and never underflows.
- Full: occupancy=DEPTH and out_ready=0 gives in_ready=0. Full with out_ready=1 gives in_ready=1, so an item enters while one leaves.
- Empty: out_valid=0; out_ready is ignored.
- in_valid=0 never alters stage contents; data of empty stages is don't-care but is not emitted.

Test Plan (WIDTH=8, DEPTH=4):
1. Reset 2 cycles, then in_data=0xA5, in_mode=01, out_ready=1, one cycle -> out_valid=1 with out_data=0x5A exactly 4 cycles after accept, for one cycle; occupancy 1 then 0.
2. Stream 0x00..0x09, mode 00, in_valid and out_ready held 1 -> in_ready stays 1; outputs 0x00..0x09 back-to-back in order.
3. out_ready=0, offer 5 samples -> 4 accepted, in_ready=0 after the 4th, occupancy=4, out_data frozen at the 1st. Then out_ready=1 -> 4 items out in order on consecutive cycles and the 5th is accepted in the same cycle the 1st leaves.
4. Mode 10, mask 0x0F, data 0x3C -> 0x33. Mode 11, data 0x01 -> 0x80. Change mode/mask each cycle; each item reflects its own accept-cycle settings.
5. Full pipeline, in_valid=1, out_ready=1 for 6 cycles -> one in and one out each cycle, occupancy constant 4.
6. 3 items in flight, assert reset 1 cycle with in_valid=1 -> next cycle out_valid=0, occupancy=0; no stale item ever emitted; post-reset traffic behaves as in scenario 1.
